// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the default counter value loaded at reset.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not-taken
    WNT = 2'b01,  // weakly not-taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } ctr_state_e;

  localparam logic [1:0] DEFAULT_INIT_STATE = WNT;

  // A counter predicts taken when its MSB is set (WT or ST).
  function automatic logic predicts_taken(input logic [1:0] state);
    return state[1];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state logic: one step toward taken
// or not-taken, clamped at ST and SNT.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  // Step the counter one position, holding at either end.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    next_state = state;
    unique case (state)
      SNT:     next_state = taken ? WNT : SNT;
      WNT:     next_state = taken ? WT  : SNT;
      WT:      next_state = taken ? ST  : WNT;
      ST:      next_state = taken ? ST  : WT;
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/branch_predictor_table.sv
// Pattern history table of 2-bit saturating counters with an optional
// non-speculative global history (gshare) folded into the index, plus
// resolved-branch and misprediction statistics.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int         INDEX_BITS = 6,
  parameter int         HIST_BITS  = 0,
  parameter logic [1:0] INIT_STATE = DEFAULT_INIT_STATE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_decode_sig,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           offset,
  output logic                  prediction,
  output logic [31:0]           branch_addr,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  branch_mem_sig,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  actual_branch_decision,
  input  logic                  mispredict,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] hist_ext;
  logic [1:0]            upd_cur;
  logic [1:0]            upd_next;
  logic                  unused_addr_bits;

  // Word-aligned PC bits select the entry; byte offset and upper PC are ignored.
  assign pc_idx           = in_addr[INDEX_BITS+1:2];
  assign unused_addr_bits = ^{in_addr[31:INDEX_BITS+2], in_addr[1:0]};

  generate
    if (HIST_BITS == 0) begin : g_bimodal
      assign hist_ext = '0;
    end else begin : g_gshare
      logic [HIST_BITS-1:0] ghr_q;
      logic [HIST_BITS:0]   ghr_shift;

      assign ghr_shift = {ghr_q, actual_branch_decision};
      assign hist_ext  = INDEX_BITS'(ghr_q);

      // Global history advances only on resolved branches, never speculatively.
      always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
          ghr_q <= '0;
        end else if (branch_mem_sig) begin
          ghr_q <= ghr_shift[HIST_BITS-1:0];
        end
      end
    end
  endgenerate

  // Prediction reads the table asynchronously in ID; no bypass from a same-cycle update.
  assign pred_idx    = pc_idx ^ hist_ext;
  assign prediction  = branch_decode_sig & predicts_taken(table_q[pred_idx]);
  assign branch_addr = in_addr + offset;

  assign upd_cur = table_q[upd_idx];

  sat_counter2 u_sat_counter2 (
    .state      (upd_cur),
    .taken      (actual_branch_decision),
    .next_state (upd_next)
  );

  // Single write port: reset loads every counter, otherwise the resolving entry steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is small flop storage with a defined start state, so each entry is reset explicitly.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= INIT_STATE;
      end
    end else if (branch_mem_sig) begin
      table_q[upd_idx] <= upd_next;
    end
  end

  // Saturating statistics for resolved branches and mispredictions.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (branch_mem_sig) begin
      if (stat_branches != 32'hFFFF_FFFF) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Self-checking bench: a bimodal and a gshare (HIST_BITS=4) instance share
// stimulus; a behavioural model of both tables, the history and the
// statistics is compared every cycle, plus directed vectors and sequences.
module tb_branch_predictor_table;

  localparam int IB      = 6;
  localparam int ENTRIES = 64;

  logic        clk;
  logic        reset;
  logic        branch_decode_sig;
  logic [31:0] in_addr;
  logic [31:0] offset;
  logic        branch_mem_sig;
  logic [IB-1:0] upd_idx;
  logic        actual_branch_decision;
  logic        mispredict;

  logic        pred_b, pred_g;
  logic [31:0] baddr_b, baddr_g;
  logic [IB-1:0] idx_b, idx_g;
  logic [31:0] sbr_b, smis_b, sbr_g, smis_g;

  branch_predictor_table #(.INDEX_BITS(IB), .HIST_BITS(0)) dut_b (
    .clk(clk), .reset(reset), .branch_decode_sig(branch_decode_sig),
    .in_addr(in_addr), .offset(offset), .prediction(pred_b),
    .branch_addr(baddr_b), .pred_idx(idx_b), .branch_mem_sig(branch_mem_sig),
    .upd_idx(upd_idx), .actual_branch_decision(actual_branch_decision),
    .mispredict(mispredict), .stat_branches(sbr_b), .stat_mispredicts(smis_b)
  );

  branch_predictor_table #(.INDEX_BITS(IB), .HIST_BITS(4)) dut_g (
    .clk(clk), .reset(reset), .branch_decode_sig(branch_decode_sig),
    .in_addr(in_addr), .offset(offset), .prediction(pred_g),
    .branch_addr(baddr_g), .pred_idx(idx_g), .branch_mem_sig(branch_mem_sig),
    .upd_idx(upd_idx), .actual_branch_decision(actual_branch_decision),
    .mispredict(mispredict), .stat_branches(sbr_g), .stat_mispredicts(smis_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counters as integers 0..3, history as an integer mod 16.
  int     m_tab_b [ENTRIES];
  int     m_tab_g [ENTRIES];
  int     m_ghr;
  longint m_br;
  longint m_mis;
  bit     model_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bim_idx(input logic [31:0] a);
    return int'((a / 4) % ENTRIES);
  endfunction

  function automatic int gsh_idx(input logic [31:0] a);
    return bim_idx(a) ^ m_ghr;
  endfunction

  // Apply one clock edge's worth of architectural behaviour to the model.
  task automatic model_edge();
    int u;
    u = int'(upd_idx);
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_tab_b[i] = 1;
        m_tab_g[i] = 1;
      end
      m_ghr = 0;
      m_br  = 0;
      m_mis = 0;
      model_valid = 1'b1;
    end else if (branch_mem_sig) begin
      if (actual_branch_decision) begin
        m_tab_b[u] = (m_tab_b[u] < 3) ? m_tab_b[u] + 1 : 3;
        m_tab_g[u] = (m_tab_g[u] < 3) ? m_tab_g[u] + 1 : 3;
      end else begin
        m_tab_b[u] = (m_tab_b[u] > 0) ? m_tab_b[u] - 1 : 0;
        m_tab_g[u] = (m_tab_g[u] > 0) ? m_tab_g[u] - 1 : 0;
      end
      m_ghr = (m_ghr * 2 + (actual_branch_decision ? 1 : 0)) % 16;
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (mispredict && m_mis < 64'hFFFF_FFFF) m_mis++;
    end
  endtask

  // Compare every DUT output against the model (inputs already settled).
  task automatic check_all();
    logic [31:0] exp_addr;
    if (model_valid) begin
      exp_addr = in_addr + offset;
      check("bim_idx",  32'(idx_b), 32'(bim_idx(in_addr)));
      check("bim_pred", 32'(pred_b), 32'(branch_decode_sig && m_tab_b[bim_idx(in_addr)] >= 2));
      check("bim_addr", baddr_b, exp_addr);
      check("gsh_idx",  32'(idx_g), 32'(gsh_idx(in_addr)));
      check("gsh_pred", 32'(pred_g), 32'(branch_decode_sig && m_tab_g[gsh_idx(in_addr)] >= 2));
      check("gsh_addr", baddr_g, exp_addr);
      check("stat_br",  sbr_b,  32'(m_br));
      check("stat_mis", smis_b, 32'(m_mis));
      check("gsh_stat_br",  sbr_g,  32'(m_br));
      check("gsh_stat_mis", smis_g, 32'(m_mis));
    end
  endtask

  // One cycle: check settled outputs, take the edge, return at the falling edge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit dec, input logic [31:0] a, input logic [31:0] off,
                       input bit mem, input logic [IB-1:0] u, input bit tk, input bit mis);
    branch_decode_sig      = dec;
    in_addr                = a;
    offset                 = off;
    branch_mem_sig         = mem;
    upd_idx                = u;
    actual_branch_decision = tk;
    mispredict             = mis;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          dec;
    logic [31:0] addr;
    logic [31:0] off;
    bit          mem;
    logic [5:0]  uidx;
    bit          taken;
    bit          exp_pred;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // Directed bimodal vectors from reset; expected values are pre-edge.
    vecs[0]  = '{1'b1, 32'h100, 32'h20, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0};   // reset state
    vecs[1]  = '{1'b1, 32'h14,  32'h0,  1'b1, 6'd5, 1'b1, 1'b0, 6'd5};   // WNT -> WT
    vecs[2]  = '{1'b1, 32'h14,  32'h0,  1'b1, 6'd5, 1'b1, 1'b1, 6'd5};   // WT  -> ST
    vecs[3]  = '{1'b1, 32'h14,  32'h0,  1'b1, 6'd5, 1'b1, 1'b1, 6'd5};   // ST stays ST
    vecs[4]  = '{1'b1, 32'h14,  32'h0,  1'b1, 6'd5, 1'b0, 1'b1, 6'd5};   // ST  -> WT
    vecs[5]  = '{1'b1, 32'h14,  32'h0,  1'b0, 6'd5, 1'b0, 1'b1, 6'd5};   // WT predicts taken
    vecs[6]  = '{1'b1, 32'hC,   32'h0,  1'b1, 6'd3, 1'b0, 1'b0, 6'd3};   // WNT -> SNT
    vecs[7]  = '{1'b1, 32'hC,   32'h0,  1'b1, 6'd3, 1'b0, 1'b0, 6'd3};   // SNT stays
    vecs[8]  = '{1'b1, 32'hC,   32'h0,  1'b1, 6'd3, 1'b0, 1'b0, 6'd3};
    vecs[9]  = '{1'b1, 32'hC,   32'h0,  1'b1, 6'd3, 1'b0, 1'b0, 6'd3};
    vecs[10] = '{1'b1, 32'hC,   32'h0,  1'b1, 6'd3, 1'b1, 1'b0, 6'd3};   // SNT -> WNT
    vecs[11] = '{1'b1, 32'hC,   32'h0,  1'b0, 6'd3, 1'b0, 1'b0, 6'd3};   // WNT not taken
    vecs[12] = '{1'b0, 32'h14,  32'h0,  1'b0, 6'd5, 1'b0, 1'b0, 6'd5};   // no branch in ID

    drive(1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    do_reset();
    #1;
    check("reset_stat_br",  sbr_b,  32'd0);
    check("reset_stat_mis", smis_b, 32'd0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].dec, vecs[i].addr, vecs[i].off, vecs[i].mem, vecs[i].uidx, vecs[i].taken, 1'b0);
      #1;
      check($sformatf("vec%0d_pred", i), 32'(pred_b), 32'(vecs[i].exp_pred));
      check($sformatf("vec%0d_idx", i),  32'(idx_b),  32'(vecs[i].exp_idx));
      if (i == 0) check("vec0_addr", baddr_b, 32'h120);
      cycle();
    end

    // Same-cycle read and write of entry 7 (WNT): old value seen, new one next cycle.
    drive(1'b1, 32'h1C, 32'h0, 1'b1, 6'd7, 1'b1, 1'b0);
    #1;
    check("bypass_same_cycle", 32'(pred_b), 32'd0);
    cycle();
    drive(1'b1, 32'h1C, 32'h0, 1'b0, 6'd7, 1'b0, 1'b0);
    #1;
    check("bypass_next_cycle", 32'(pred_b), 32'd1);
    cycle();
    drive(1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0, 6'd0, 1'b0, 1'b0);
    #1;
    check("addr_wrap", baddr_b, 32'hFFFF_FFFC);
    cycle();

    // Gshare history T,T,N,T -> ghr 4'b1101.
    do_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 6'd0, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b0); cycle();
    drive(1'b1, 32'h40, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    #1;
    check("gshare_idx", 32'(idx_g), 32'h1D);
    check("bimodal_idx_0x40", 32'(idx_b), 32'h10);
    cycle();

    // Reset wins over a simultaneous update; stale updates later apply normally.
    drive(1'b1, 32'h14, 32'h0, 1'b1, 6'd5, 1'b1, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(1'b1, 32'h14, 32'h0, 1'b0, 6'd5, 1'b0, 1'b0);
    #1;
    check("reset_prio_pred", 32'(pred_b), 32'd0);
    check("reset_prio_br",   sbr_b,  32'd0);
    check("reset_prio_mis",  smis_b, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 6'(i + 9), 1'b0, 1'b1);
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1);  // mispredict alone is ignored
    cycle();
    #1;
    check("post_reset_br",  sbr_b,  32'd3);
    check("post_reset_mis", smis_b, 32'd3);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
      if (i % 5 == 0) in_addr = 32'($urandom_range(0, 255));
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
